// File: rtl/mem_rd_pkg.sv
// Shared types, constants and helpers for the skewed memory read controller.
package mem_rd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;

    // Parked lane address; users truncate to their address width.
    localparam logic [63:0] ADDR_INVALID = '1;

    // Limit a requested row count to the per-transfer cap.
    function automatic logic [31:0] clamp_rows(input logic [31:0] rows, input logic [31:0] cap);
        return (rows > cap) ? cap : rows;
    endfunction

endpackage

// File: rtl/mem_rd_vld_pipe.sv
// WIDTH-wide, DEPTH-deep delay line with synchronous active-low clear.
module mem_rd_vld_pipe
    import mem_rd_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stage_q [DEPTH];
    logic [WIDTH-1:0] stage_d [DEPTH];

    // Shift by one stage per clock.
    always_comb begin
        stage_d[0] = din;
        for (int unsigned i = 1; i < DEPTH; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    // Stage registers; clear drops everything in flight.
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            stage_q <= '{default: '0};
        end else begin
            stage_q <= stage_d;
        end
    end

    assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/mem_rd_skew_ctrl.sv
// Skewed read controller for a SYS_ROW-lane systolic array: lane i issues
// its reads i issue-cycles after lane 0, with stride addressing, global stall
// and a latency-aligned data-valid output.
// Optional build macro MEM_RD_SKEW_REVERSE_EN adds skew_rev, which makes the
// skew start at lane SYS_ROW-1 and end at lane 0.
module mem_rd_skew_ctrl
    import mem_rd_pkg::*;
#(
    parameter int unsigned SYS_ROW    = 16,
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned CNT_WIDTH  = 16,
    parameter int unsigned MAX_ROWS   = 256,
    parameter int unsigned RD_LATENCY = 2
) (
    input  logic                                 clk,
    input  logic                                 rstn,
    input  logic                                 start,
    input  logic [CNT_WIDTH-1:0]                 num_row,
    input  logic [ADDR_WIDTH-1:0]                base_addr,
    input  logic [ADDR_WIDTH-1:0]                row_stride,
    input  logic                                 stall,
`ifdef MEM_RD_SKEW_REVERSE_EN
    input  logic                                 skew_rev,
`endif
    output logic                                 busy,
    output logic                                 done,
    output logic [SYS_ROW-1:0]                   rd_en,
    output logic [SYS_ROW-1:0][ADDR_WIDTH-1:0]   rd_addr,
    output logic [SYS_ROW-1:0]                   data_vld
);

    localparam int unsigned           DC_W      = $clog2(RD_LATENCY + 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_INV  = ADDR_WIDTH'(ADDR_INVALID);
    localparam logic [SYS_ROW-1:0]    LAST_ONLY = {1'b1, {(SYS_ROW-1){1'b0}}};

    state_e                             state_q, state_d;
    logic [CNT_WIDTH-1:0]               cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0]               n_q, n_d;
    logic [ADDR_WIDTH-1:0]              stride_q, stride_d;
    // Logical-lane issue pattern of the most recent unstalled issue cycle.
    logic [SYS_ROW-1:0]                 sh_q, sh_d;
    logic [SYS_ROW-1:0]                 rd_en_q, rd_en_d;
    logic [SYS_ROW-1:0][ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic [DC_W-1:0]                    dc_q, dc_d;
    logic                               busy_q, busy_d;
    logic                               done_q, done_d;
    logic                               issue0;
    logic [SYS_ROW-1:0]                 prev_phys, next_phys;
    logic                               rev;

`ifdef MEM_RD_SKEW_REVERSE_EN
    logic rev_q, rev_d;

    // Skew direction latched with the transfer.
    always_comb begin
        rev_d = rev_q;
        if (state_q == IDLE && start) begin
            rev_d = skew_rev;
        end
    end

    // Skew direction register.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            rev_q <= 1'b0;
        end else begin
            rev_q <= rev_d;
        end
    end

    assign rev = rev_q;
`else
    assign rev = 1'b0;
`endif

    // Next-state, issue and address logic.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        n_d       = n_q;
        stride_d  = stride_q;
        sh_d      = sh_q;
        rd_en_d   = '0;
        rd_addr_d = rd_addr_q;
        dc_d      = dc_q;
        busy_d    = (state_q != IDLE);
        done_d    = 1'b0;
        issue0    = (cnt_q < n_q);
        prev_phys = '0;
        next_phys = '0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    n_d       = CNT_WIDTH'(clamp_rows(32'(num_row), 32'(MAX_ROWS)));
                    stride_d  = row_stride;
                    cnt_d     = '0;
                    sh_d      = '0;
                    dc_d      = '0;
                    rd_addr_d = {SYS_ROW{base_addr}};
                    state_d   = (n_d == '0) ? DRAIN : RUN;
                end
            end
            RUN: begin
                if (!stall) begin
                    sh_d = {sh_q[SYS_ROW-2:0], issue0};
                    if (issue0) begin
                        cnt_d = cnt_q + CNT_WIDTH'(1);
                    end
                    // Map logical skew order onto physical lanes.
                    for (int unsigned p = 0; p < SYS_ROW; p++) begin
                        prev_phys[p] = rev ? sh_q[SYS_ROW-1-p] : sh_q[p];
                        next_phys[p] = rev ? sh_d[SYS_ROW-1-p] : sh_d[p];
                        rd_en_d[p]   = next_phys[p];
                        if (prev_phys[p] && next_phys[p]) begin
                            rd_addr_d[p] = rd_addr_q[p] + stride_q;
                        end else if (prev_phys[p]) begin
                            rd_addr_d[p] = ADDR_INV;
                        end
                    end
                    // Only the last logical lane still reading: final issue.
                    if (sh_d == LAST_ONLY) begin
                        state_d = DRAIN;
                        dc_d    = '0;
                    end
                end
            end
            DRAIN: begin
                sh_d      = '0;
                rd_addr_d = {SYS_ROW{ADDR_INV}};
                dc_d      = dc_q + DC_W'(1);
                if (dc_q == DC_W'(RD_LATENCY)) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            n_q       <= '0;
            stride_q  <= '0;
            sh_q      <= '0;
            rd_en_q   <= '0;
            rd_addr_q <= {SYS_ROW{ADDR_INV}};
            dc_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            n_q       <= n_d;
            stride_q  <= stride_d;
            sh_q      <= sh_d;
            rd_en_q   <= rd_en_d;
            rd_addr_q <= rd_addr_d;
            dc_q      <= dc_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign rd_en   = rd_en_q;
    assign rd_addr = rd_addr_q;

    // Data-valid follows rd_en by the memory read latency.
    mem_rd_vld_pipe #(
        .WIDTH (SYS_ROW),
        .DEPTH (RD_LATENCY)
    ) u_vld_pipe (
        .clk   (clk),
        .clr_n (rstn),
        .din   (rd_en_q),
        .dout  (data_vld)
    );

endmodule

// File: tb/tb_mem_rd_skew_ctrl.sv
// Directed self-checking bench for mem_rd_skew_ctrl (SYS_ROW=4, RD_LATENCY=2).
// Cycle c means the outputs seen just after the clock edge that sampled the
// inputs driven for cycle c; start is driven for cycle 0.
module tb_mem_rd_skew_ctrl;

    localparam int unsigned S  = 4;
    localparam int unsigned AW = 16;
    localparam int unsigned CW = 16;
    localparam int unsigned L  = 2;

    logic                       clk;
    logic                       rstn;
    logic                       start;
    logic [CW-1:0]              num_row;
    logic [AW-1:0]              base_addr;
    logic [AW-1:0]              row_stride;
    logic                       stall;
`ifdef MEM_RD_SKEW_REVERSE_EN
    logic                       skew_rev;
`endif
    logic                       busy;
    logic                       done;
    logic [S-1:0]               rd_en;
    logic [S-1:0][AW-1:0]       rd_addr;
    logic [S-1:0]               data_vld;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    mem_rd_skew_ctrl #(
        .SYS_ROW    (S),
        .ADDR_WIDTH (AW),
        .CNT_WIDTH  (CW),
        .MAX_ROWS   (256),
        .RD_LATENCY (L)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .start      (start),
        .num_row    (num_row),
        .base_addr  (base_addr),
        .row_stride (row_stride),
        .stall      (stall),
`ifdef MEM_RD_SKEW_REVERSE_EN
        .skew_rev   (skew_rev),
`endif
        .busy       (busy),
        .done       (done),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .data_vld   (data_vld)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string name, input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s.%s: observed 0x%0h expected 0x%0h at t-cycle %0d", name, tag, obs, exp, cyc);
        end
    endtask

    task automatic chk_idle_outputs(input string name);
        chk(name, "busy", 64'(busy), 64'(0));
        chk(name, "done", 64'(done), 64'(0));
        chk(name, "rd_en", 64'(rd_en), 64'(0));
        chk(name, "data_vld", 64'(data_vld), 64'(0));
        for (int p = 0; p < S; p++) begin
            chk(name, "rd_addr_inv", 64'(rd_addr[p]), 64'(16'hFFFF));
        end
    endtask

    // One transfer with a per-cycle reference: issue step advances on every
    // unstalled cycle from cycle 1; logical lane j reads steps 1+j .. n+j.
    task automatic do_xfer(input string name, input int n_in, input int n_exp,
                           input logic [15:0] base, input logic [15:0] stride, input logic rev,
                           input int st_lo, input int st_hi, input int glitch_c, input int exp_done);
        logic [S-1:0] hist [0:511];
        logic [S-1:0] exp_en;
        logic [S-1:0] exp_vld;
        logic [15:0]  exp_addr;
        int           rd_cnt [S];
        int           step;
        int           j;
        logic         st;
        step = 0;
        for (int p = 0; p < S; p++) rd_cnt[p] = 0;
        for (int c = 0; c <= exp_done + 1; c++) begin
            st = (c >= st_lo) && (c <= st_hi);
            if (c == glitch_c) begin
                start      = 1'b1;
                num_row    = 16'd7;
                base_addr  = 16'h0050;
                row_stride = 16'd9;
            end else begin
                start      = (c == 0);
                num_row    = 16'(n_in);
                base_addr  = base;
                row_stride = stride;
            end
            stall = st;
`ifdef MEM_RD_SKEW_REVERSE_EN
            skew_rev = (c == glitch_c) ? ~rev : rev;
`endif
            tick();
            if (c >= 1 && !st) step++;
            exp_en = '0;
            for (int p = 0; p < S; p++) begin
                j = rev ? (S - 1 - p) : p;
                exp_en[p] = (c >= 1) && !st && (step >= 1 + j) && (step <= n_exp + j);
            end
            hist[c] = exp_en;
            exp_vld = (c >= L) ? hist[c-L] : '0;
            chk(name, "rd_en", 64'(rd_en), 64'(exp_en));
            chk(name, "data_vld", 64'(data_vld), 64'(exp_vld));
            chk(name, "busy", 64'(busy), 64'((c >= 1) && (c <= exp_done)));
            chk(name, "done", 64'(done), 64'(c == exp_done));
            for (int p = 0; p < S; p++) begin
                if (rd_en[p]) rd_cnt[p]++;
                if (exp_en[p]) begin
                    j = rev ? (S - 1 - p) : p;
                    exp_addr = base + 16'(step - 1 - j) * stride;
                    chk(name, "rd_addr", 64'(rd_addr[p]), 64'(exp_addr));
                end
            end
        end
        for (int p = 0; p < S; p++) begin
            chk(name, "reads_per_lane", 64'(rd_cnt[p]), 64'(n_exp));
            chk(name, "rd_addr_parked", 64'(rd_addr[p]), 64'(16'hFFFF));
        end
        start = 1'b0;
        stall = 1'b0;
    endtask

    initial begin
        rstn       = 1'b0;
        start      = 1'b0;
        num_row    = '0;
        base_addr  = '0;
        row_stride = '0;
        stall      = 1'b0;
`ifdef MEM_RD_SKEW_REVERSE_EN
        skew_rev   = 1'b0;
`endif
        repeat (3) tick();
        chk_idle_outputs("reset");
        rstn = 1'b1;
        tick();
        chk_idle_outputs("post_reset");

        // Basic skew, N=3: done cycle 9.
        do_xfer("basic", 3, 3, 16'h0010, 16'h0001, 1'b0, -1, -1, -1, 9);
        // Stride with silent wrap: FFFE, 0001, 0004.
        do_xfer("wrap", 3, 3, 16'hFFFE, 16'h0003, 1'b0, -1, -1, -1, 9);
        // Stall in cycles 2-4 pushes done to cycle 12.
        do_xfer("stall", 3, 3, 16'h0010, 16'h0001, 1'b0, 2, 4, -1, 12);
        // Stall together with start: issue deferred to cycle 3, done 11.
        do_xfer("stall_start", 3, 3, 16'h0200, 16'h0004, 1'b0, 0, 2, -1, 11);
        // Start pulsed mid-transfer is ignored.
        do_xfer("ignored_start", 3, 3, 16'h0010, 16'h0001, 1'b0, -1, -1, 2, 9);
        // Zero rows: no reads, done in cycle 3.
        do_xfer("zero", 0, 0, 16'h0010, 16'h0001, 1'b0, -1, -1, -1, 3);
        // Clamp 1000 rows to 256: done at 256+4+2.
        do_xfer("clamp", 1000, 256, 16'h1000, 16'h0002, 1'b0, -1, -1, -1, 262);
`ifdef MEM_RD_SKEW_REVERSE_EN
        // Reversed skew: lane 3 first, lane 0 last.
        do_xfer("reverse", 3, 3, 16'h0010, 16'h0001, 1'b1, -1, -1, -1, 9);
`endif

        // Reset abort: reset sampled for cycle 5 kills the transfer.
        num_row    = 16'd3;
        base_addr  = 16'h0010;
        row_stride = 16'h0001;
        start      = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        chk("abort", "rd_en_c4", 64'(rd_en), 64'(4'b1110));
        chk("abort", "data_vld_c4", 64'(data_vld), 64'(4'b0011));
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        tick();
        chk_idle_outputs("abort_c6");
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("abort", "no_done", 64'(done), 64'(0));
            chk("abort", "no_busy", 64'(busy), 64'(0));
        end

        // Controller is usable again after the abort.
        do_xfer("after_abort", 2, 2, 16'h0400, 16'h0010, 1'b0, -1, -1, -1, 8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
